// File: rtl/dma_pkg.sv
// Shared definitions for the DMA input/output bridges: transfer FSM encoding,
// default bus widths and a FIFO sizing helper.
package dma_pkg;

  localparam int DMA_DATA_W = 8;
  localparam int DMA_ADDR_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } dma_state_t;

  // Occupancy counters must represent 0..depth inclusive.
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dma_output_bridge_if.sv
// AXI-Stream link from the output bridge to the S2MM engine.
interface dma_output_bridge_if #(
  parameter int DATA_W = dma_pkg::DMA_DATA_W
) ();

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic              tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/axis_out_fifo.sv
// Small synchronous FIFO with first-word fall-through: a word pushed into an
// empty FIFO is visible on head in the same cycle and may be popped straight away.
module axis_out_fifo
  import dma_pkg::*;
#(
  parameter  int WIDTH = 9,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = fifo_cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             bypass;
  logic             store;
  logic             take;

  assign empty  = (count == '0);
  assign bypass = empty && push && pop;
  assign store  = push && !bypass;
  assign take   = pop && !empty;
  assign head   = empty ? push_data : mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + PTR_W'(1);
      if (take)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(store) - CNT_W'(take);
    end
  end

  // NOTE: storage is deliberately not reset; pointers and count define what
  // is valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr] <= push_data;
  end

  // Upstream throttling must keep a full FIFO from being written.
  always_ff @(posedge clk) begin
    if (!reset) assert (!(store && !take && count == CNT_W'(DEPTH)));
  end

endmodule

// File: rtl/dma_output_bridge.sv
// Drains one tile from output buffer A or B and streams it to the S2MM channel,
// throttling buffer reads so the 1-cycle read latency never overflows the FIFO.
module dma_output_bridge
  import dma_pkg::*;
#(
  parameter int DATA_W     = DMA_DATA_W,
  parameter int ADDR_W     = DMA_ADDR_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              active_out_buf,
  output logic [ADDR_W-1:0] bufA_addr,
  output logic              bufA_re,
  input  logic [DATA_W-1:0] bufA_rdata,
  output logic [ADDR_W-1:0] bufB_addr,
  output logic              bufB_re,
  input  logic [DATA_W-1:0] bufB_rdata,
  dma_output_bridge_if.master m_axis,
  output logic              busy,
  output logic              dma_done
);

  localparam int              CNT_W       = fifo_cnt_w(FIFO_DEPTH);
  localparam logic [ADDR_W:0] ONE         = (ADDR_W + 1)'(1);
  localparam logic [CNT_W-1:0] ISSUE_LIMIT = CNT_W'(FIFO_DEPTH - 2);

  dma_state_t        state_q;
  dma_state_t        state_d;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   rd_cnt;
  logic              sel_q;
  logic              in_flight_q;
  logic              last_q;
  logic              accept;
  logic              issue;
  logic              issue_last;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  occupancy;
  logic              fifo_empty;
  logic [DATA_W:0]   push_data;
  logic [DATA_W:0]   head;
  logic              tvalid;
  logic              pop;

  assign accept     = (state_q == ST_IDLE) && start;
  // A read in flight already owns a FIFO slot, so it counts as occupied.
  assign occupancy  = fifo_count + CNT_W'(in_flight_q);
  assign issue      = (state_q == ST_READ) && (rd_cnt != len_q) && (occupancy <= ISSUE_LIMIT);
  assign issue_last = (rd_cnt == len_q - ONE);

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    busy     = 1'b0;
    dma_done = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = (len == '0) ? ST_DONE : ST_READ;
      end
      ST_READ: begin
        busy = 1'b1;
        if (issue && issue_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (pop && head[DATA_W]) state_d = ST_DONE;
      end
      ST_DONE: begin
        dma_done = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Only the selected buffer sees reads; idle addresses park at zero.
  always_comb begin
    bufA_re   = issue && !sel_q;
    bufB_re   = issue && sel_q;
    bufA_addr = bufA_re ? rd_cnt[ADDR_W-1:0] : '0;
    bufB_addr = bufB_re ? rd_cnt[ADDR_W-1:0] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_q       <= '0;
      sel_q       <= 1'b0;
      rd_cnt      <= '0;
      in_flight_q <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      in_flight_q <= issue;
      last_q      <= issue && issue_last;
      if (accept) begin
        len_q  <= len;
        sel_q  <= active_out_buf;
        rd_cnt <= '0;
      end else if (issue) begin
        rd_cnt <= rd_cnt + ONE;
      end
    end
  end

  // Read data returns one cycle after re and is tagged with its last flag.
  assign push_data = {last_q, (sel_q ? bufB_rdata : bufA_rdata)};

  axis_out_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_flight_q),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign tvalid        = !fifo_empty || in_flight_q;
  assign pop           = tvalid && m_axis.tready;
  assign m_axis.tvalid = tvalid;
  assign m_axis.tdata  = tvalid ? head[DATA_W-1:0] : '0;
  assign m_axis.tlast  = tvalid && head[DATA_W];

endmodule

// File: tb/tb_dma_output_bridge.sv
// Directed bench for dma_output_bridge: buffer models, a negedge stream
// monitor and hand-built expectations for each transfer scenario.
module tb_dma_output_bridge;
  import dma_pkg::*;

  localparam int DATA_W     = DMA_DATA_W;
  localparam int ADDR_W     = DMA_ADDR_W;
  localparam int FIFO_DEPTH = 4;
  localparam int NWORDS     = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W:0]   len = '0;
  logic              active_out_buf = 1'b0;
  logic [ADDR_W-1:0] bufA_addr, bufB_addr;
  logic              bufA_re, bufB_re;
  logic [DATA_W-1:0] bufA_rdata = '0;
  logic [DATA_W-1:0] bufB_rdata = '0;
  logic              busy, dma_done;

  dma_output_bridge_if #(.DATA_W(DATA_W)) m_axis ();

  dma_output_bridge #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .active_out_buf(active_out_buf),
    .bufA_addr(bufA_addr), .bufA_re(bufA_re), .bufA_rdata(bufA_rdata),
    .bufB_addr(bufB_addr), .bufB_re(bufB_re), .bufB_rdata(bufB_rdata),
    .m_axis(m_axis), .busy(busy), .dma_done(dma_done)
  );

  always #5 clk = ~clk;

  // Buffer contents: hand-picked heads, then simple arithmetic fill.
  logic [7:0] a_head [4];
  logic [7:0] b_tab  [8];
  logic [7:0] mem_a  [NWORDS];
  logic [7:0] mem_b  [NWORDS];

  function automatic logic [7:0] exp_word(input logic sel, input int idx);
    if (!sel) return (idx < 4) ? a_head[idx] : 8'(idx * 7 + 3);
    return (idx < 8) ? b_tab[idx] : 8'(idx * 13 + 5);
  endfunction

  always @(posedge clk) begin
    if (bufA_re) bufA_rdata <= mem_a[bufA_addr];
    if (bufB_re) bufB_rdata <= mem_b[bufB_addr];
  end

  logic tready_toggle = 1'b0;
  logic tready_level  = 1'b0;
  always @(posedge clk) m_axis.tready <= tready_toggle ? ~m_axis.tready : tready_level;

  // Monitor: observations taken on the falling edge.
  int         edge_cnt = 0;
  logic       mon_clear = 1'b0;
  logic [8:0] beats [$];
  int a_re_n = 0, b_re_n = 0, addr_bad = 0, rd_seq = 0, stall_bad = 0, tlast_n = 0, done_n = 0;
  int first_re_e = -1, first_valid_e = -1, beat_e_first = -1, beat_e_last = -1, done_e = -1;
  logic       prev_stall = 1'b0;
  logic [8:0] prev_beat = '0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(negedge clk) begin
    if (mon_clear) begin
      beats.delete();
      a_re_n <= 0; b_re_n <= 0; addr_bad <= 0; rd_seq <= 0; stall_bad <= 0;
      tlast_n <= 0; done_n <= 0;
      first_re_e <= -1; first_valid_e <= -1; beat_e_first <= -1; beat_e_last <= -1; done_e <= -1;
      prev_stall <= 1'b0;
    end else begin
      if (bufA_re) a_re_n <= a_re_n + 1;
      if (bufB_re) b_re_n <= b_re_n + 1;
      if (bufA_re || bufB_re) begin
        if ((bufA_re ? bufA_addr : bufB_addr) != rd_seq[ADDR_W-1:0]) addr_bad <= addr_bad + 1;
        rd_seq <= rd_seq + 1;
        if (first_re_e < 0) first_re_e <= edge_cnt;
      end
      if (m_axis.tvalid && first_valid_e < 0) first_valid_e <= edge_cnt;
      if (prev_stall && (!m_axis.tvalid || {m_axis.tlast, m_axis.tdata} != prev_beat))
        stall_bad <= stall_bad + 1;
      prev_stall <= m_axis.tvalid && !m_axis.tready;
      prev_beat  <= {m_axis.tlast, m_axis.tdata};
      if (m_axis.tvalid && m_axis.tready) begin
        if (beats.size() == 0) beat_e_first <= edge_cnt;
        beat_e_last <= edge_cnt;
        beats.push_back({m_axis.tlast, m_axis.tdata});
        if (m_axis.tlast) tlast_n <= tlast_n + 1;
      end
      if (dma_done) begin
        done_n <= done_n + 1;
        if (done_e < 0) done_e <= edge_cnt;
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, expv, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // Start sampled at the edge numbered s; returns just after that edge.
  task automatic do_start(input int l, input logic sel, output int s);
    tick();
    start = 1'b1; len = (ADDR_W + 1)'(l); active_out_buf = sel; mon_clear = 1'b1;
    s = edge_cnt + 1;
    tick();
    start = 1'b0; mon_clear = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_n == 0 && n < budget) begin
      settle();
      n++;
    end
    check({tag, "_done_seen"}, 32'(done_n != 0), 1);
  endtask

  task automatic verify_beats(input string tag, input logic sel, input int l);
    int bad = 0;
    check({tag, "_beat_count"}, beats.size(), l);
    for (int i = 0; i < beats.size() && i < l; i++) begin
      logic [8:0] exp_beat;
      exp_beat = {(i == l - 1), exp_word(sel, i)};
      if (l <= 16) check($sformatf("%s_beat%0d", tag, i), 32'(beats[i]), 32'(exp_beat));
      else if (beats[i] !== exp_beat) bad++;
    end
    if (l > 16) check({tag, "_beat_data"}, bad, 0);
    check({tag, "_tlast_count"}, tlast_n, 1);
    check({tag, "_addr_seq"}, addr_bad, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, n;
    a_head = '{8'd11, 8'd22, 8'd33, 8'd44};
    b_tab  = '{8'h3C, 8'hA5, 8'h01, 8'hFE, 8'h77, 8'h80, 8'h5A, 8'hC3};
    for (int i = 0; i < NWORDS; i++) begin
      mem_a[i] = exp_word(1'b0, i);
      mem_b[i] = exp_word(1'b1, i);
    end

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check("rst_tvalid", m_axis.tvalid, 0);
    check("rst_tdata",  m_axis.tdata, 0);
    check("rst_tlast",  m_axis.tlast, 0);
    check("rst_busy",   busy, 0);
    check("rst_done",   dma_done, 0);
    check("rst_re",     {bufA_re, bufB_re}, 0);
    check("rst_addr",   {bufA_addr, bufB_addr}, 0);
    tick();
    reset = 1'b0;

    // T1: len=4 from A, tready high
    tready_level = 1'b1;
    tick();
    do_start(4, 1'b0, s);
    check("t1_busy", busy, 1);
    wait_done("t1", 50);
    repeat (3) tick();
    settle();
    verify_beats("t1", 1'b0, 4);
    check("t1_first_re",    first_re_e, s);
    check("t1_first_valid", first_valid_e, s + 1);
    check("t1_beat_first",  beat_e_first, s + 1);
    check("t1_beat_last",   beat_e_last, s + 4);
    check("t1_done_cycle",  done_e, s + 5);
    check("t1_done_count",  done_n, 1);
    check("t1_a_reads",     a_re_n, 4);
    check("t1_b_reads",     b_re_n, 0);
    check("t1_busy_after",  busy, 0);

    // T2: len=8 from B, tready toggling
    tready_toggle = 1'b1;
    do_start(8, 1'b1, s);
    wait_done("t2", 100);
    repeat (3) tick();
    settle();
    verify_beats("t2", 1'b1, 8);
    check("t2_first_re",   first_re_e, s);
    check("t2_stall_hold", stall_bad, 0);
    check("t2_a_reads",    a_re_n, 0);
    check("t2_b_reads",    b_re_n, 8);
    check("t2_done_count", done_n, 1);
    tready_toggle = 1'b0;

    // T3: len=6 from A, tready low for 20 cycles
    tready_level = 1'b0;
    tick();
    do_start(6, 1'b0, s);
    repeat (20) tick();
    settle();
    check("t3_reads_while_stalled", 32'(a_re_n <= FIFO_DEPTH - 1), 1);
    check("t3_reads_nonzero",       32'(a_re_n > 0), 1);
    check("t3_no_beats_stalled",    beats.size(), 0);
    check("t3_tvalid_stalled",      m_axis.tvalid, 1);
    check("t3_first_re",            first_re_e, s);
    tready_level = 1'b1;
    wait_done("t3", 100);
    repeat (3) tick();
    settle();
    verify_beats("t3", 1'b0, 6);
    check("t3_stall_hold", stall_bad, 0);
    check("t3_a_reads",    a_re_n, 6);

    // T4: len=0
    do_start(0, 1'b0, s);
    check("t4_busy_in_done", busy, 0);
    check("t4_done_now",     dma_done, 1);
    repeat (4) tick();
    settle();
    check("t4_done_cycle", done_e, s);
    check("t4_done_count", done_n, 1);
    check("t4_no_tvalid",  first_valid_e, -1);
    check("t4_no_reads",   a_re_n + b_re_n, 0);

    // T5: full buffer from A, with an ignored second start
    do_start(NWORDS, 1'b0, s);
    repeat (100) tick();
    start = 1'b1; len = 13'd5; active_out_buf = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t5", 6000);
    repeat (3) tick();
    settle();
    verify_beats("t5", 1'b0, NWORDS);
    check("t5_first_valid", first_valid_e, s + 1);
    check("t5_no_bubbles",  beat_e_last - beat_e_first, NWORDS - 1);
    check("t5_a_reads",     a_re_n, NWORDS);
    check("t5_b_reads",     b_re_n, 0);
    check("t5_done_count",  done_n, 1);

    // T6: reset after the third beat of len=10, then a fresh len=2 transfer
    do_start(10, 1'b1, s);
    n = 0;
    while (beats.size() < 3 && n < 50) begin
      settle();
      n++;
    end
    check("t6_beat3_seen", 32'(beats.size() >= 3), 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("t6_rst_tvalid", m_axis.tvalid, 0);
    check("t6_rst_tdata",  m_axis.tdata, 0);
    check("t6_rst_tlast",  m_axis.tlast, 0);
    check("t6_rst_busy",   busy, 0);
    check("t6_rst_re",     {bufA_re, bufB_re}, 0);
    repeat (5) tick();
    settle();
    check("t6_no_done",  done_n, 0);
    check("t6_aborted",  32'(beats.size() < 10), 1);
    do_start(2, 1'b0, s);
    wait_done("t6b", 50);
    repeat (3) tick();
    settle();
    verify_beats("t6b", 1'b0, 2);
    check("t6b_first_re", first_re_e, s);
    check("t6b_a_reads",  a_re_n, 2);
    check("t6b_done_count", done_n, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
